// File: rtl/motor_pwm_pkg.sv
// rtl/motor_pwm_pkg.sv - shared types, constants and threshold helper for the motor PWM stage
// Contents:
//   ramp_state_t  : soft-start/soft-stop ramp state
//   MAX_LEVEL     : highest commandable speed level
//   level_to_thr  : speed level -> number of high cycles per PWM period
package motor_pwm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RAMP_UP,
      RAMP_DOWN,
      HOLD
   } ramp_state_t;

   localparam int MAX_LEVEL = 15;

   // PERIOD_CYCLES is a multiple of 15, so MAX_LEVEL maps to exactly one full period.
   function automatic int unsigned level_to_thr(input logic [3:0] level,
                                                input int unsigned period_cycles);
      return 32'(level) * (period_cycles / 32'(MAX_LEVEL));
   endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - free-running PWM period counter with boundary pulse
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous clear; holds the count at 0 while high
//   count    : position within the period, 0..PERIOD_CYCLES-1
//   boundary : high on the last cycle of a period (count == PERIOD_CYCLES-1)
module pwm_period_counter #(
   parameter int PERIOD_CYCLES = 1000,
   parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             boundary
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

   // A cleared counter never reports a boundary, so nothing downstream steps while held.
   assign boundary = (count == LAST) && !clear;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear || boundary) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// rtl/motor_pwm_ctrl.sv - speed command latch, soft ramp and fixed-period PWM for the motor driver
// Ports:
//   FPGA_clk     : system clock
//   FPGA_reset_n : asynchronous active-low reset
//   cmd_data     : 4-bit speed command from the SPI slave
//   cmd_valid    : one-cycle strobe qualifying cmd_data
//   motor_enable : level enable; low stops the motor on the next edge
//   pwm_out      : registered PWM to the motor driver
//   level_out    : currently applied speed level
//   at_target    : applied level equals the latched target
module motor_pwm_ctrl
   import motor_pwm_pkg::*;
#(
   parameter int PERIOD_CYCLES = 1000,
   parameter int RAMP_PERIODS  = 64,
   parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
   input  logic       FPGA_clk,
   input  logic       FPGA_reset_n,
   input  logic [3:0] cmd_data,
   input  logic       cmd_valid,
   input  logic       motor_enable,
   output logic       pwm_out,
   output logic [3:0] level_out,
   output logic       at_target
);

   localparam int THR_W  = CNT_W + 1;
   localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);

   logic [CNT_W-1:0]  count;
   logic              boundary;
   logic              step_due;
   logic [RAMP_W-1:0] ramp_cnt;
   logic [3:0]        target;
   logic [3:0]        level;
   logic [3:0]        level_next;
   logic [THR_W-1:0]  thr;
   ramp_state_t       state;
   ramp_state_t       state_next;

   pwm_period_counter #(
      .PERIOD_CYCLES (PERIOD_CYCLES),
      .CNT_W         (CNT_W)
   ) u_period (
      .clk      (FPGA_clk),
      .reset_n  (FPGA_reset_n),
      .clear    (!motor_enable),
      .count    (count),
      .boundary (boundary)
   );

   assign step_due = boundary && (ramp_cnt == RAMP_LAST);

   // One extra bit so full scale (thr == PERIOD_CYCLES) keeps the output high on every count.
   assign thr = THR_W'(level_to_thr(level, PERIOD_CYCLES));

   // Step direction follows level vs target directly, so a reversal mid-ramp
   // takes effect on the very next step without waiting for a state change.
   always_comb begin
      level_next = level;
      if (step_due) begin
         if (target > level) begin
            level_next = level + 4'd1;
         end else if (target < level) begin
            level_next = level - 4'd1;
         end
      end

      if (level_next == target) begin
         state_next = (level_next == 4'd0) ? IDLE : HOLD;
      end else if (target > level_next) begin
         state_next = RAMP_UP;
      end else begin
         state_next = RAMP_DOWN;
      end
   end

   always_ff @(posedge FPGA_clk or negedge FPGA_reset_n) begin
      if (!FPGA_reset_n) begin
         ramp_cnt <= '0;
         target   <= '0;
         level    <= '0;
         state    <= IDLE;
         pwm_out  <= 1'b0;
      end else if (!motor_enable) begin
         // Target is retained so re-enabling ramps back toward the last command.
         ramp_cnt <= '0;
         level    <= '0;
         state    <= IDLE;
         pwm_out  <= 1'b0;
      end else begin
         if (cmd_valid) begin
            target <= cmd_data;
         end
         if (boundary) begin
            ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_W'(1);
            level    <= level_next;
            state    <= state_next;
         end
         // IDLE always has level 0; the gate just makes the stopped output explicit.
         pwm_out <= (state != IDLE) && ({1'b0, count} < thr);
      end
   end

   assign level_out = level;
   assign at_target = (level == target);

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb/tb_motor_pwm_ctrl.sv - self-checking bench for motor_pwm_ctrl (PERIOD_CYCLES=30, RAMP_PERIODS=2)
module tb_motor_pwm_ctrl;
   import motor_pwm_pkg::*;

   localparam int P = 30;
   localparam int R = 2;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       en        = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd       = 4'd0;
   logic       pwm_out;
   logic [3:0] level_out;
   logic       at_target;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: time since (re)start in cycles; position and period index follow by division.
   int m_t      = 0;
   int m_level  = 0;
   int m_target = 0;
   int m_pwm    = 0;
   int m_pos;
   int m_per;

   motor_pwm_ctrl #(
      .PERIOD_CYCLES (P),
      .RAMP_PERIODS  (R)
   ) dut (
      .FPGA_clk     (clk),
      .FPGA_reset_n (rst_n),
      .cmd_data     (cmd),
      .cmd_valid    (cmd_valid),
      .motor_enable (en),
      .pwm_out      (pwm_out),
      .level_out    (level_out),
      .at_target    (at_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t = 0; m_level = 0; m_target = 0; m_pwm = 0;
      end else if (!en) begin
         m_t = 0; m_level = 0; m_pwm = 0;
      end else begin
         m_pos = m_t % P;
         m_per = m_t / P;
         m_pwm = (m_pos < m_level * (P / 15)) ? 1 : 0;
         if (m_pos == P - 1 && (m_per % R) == R - 1) begin
            if (m_target > m_level) m_level = m_level + 1;
            else if (m_target < m_level) m_level = m_level - 1;
         end
         if (cmd_valid) m_target = int'(cmd);
         m_t = m_t + 1;
      end
   end

   always @(negedge clk) begin
      check("model_pwm_out", int'(pwm_out), m_pwm);
      check("model_level_out", int'(level_out), m_level);
      check("model_at_target", int'(at_target), (m_level == m_target) ? 1 : 0);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int v);
      cmd = 4'(v);
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_level(input int lvl, input int budget);
      int n;
      n = 0;
      while (int'(level_out) != lvl && n < budget) begin
         tick(1);
         n++;
      end
      check("wait_level", int'(level_out), lvl);
   endtask

   initial begin
      int highs;

      // 1: reset, a short run, async reset mid-ramp, then quiet periods
      #1 rst_n = 1'b0;
      tick(3);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_level", int'(level_out), 0);
      check("rst_at_target", int'(at_target), 1);
      rst_n = 1'b1;
      pulse(4);
      tick(200);
      check("pre_reset_level", int'(level_out), 3);
      rst_n = 1'b0;
      #1;
      check("async_rst_level", int'(level_out), 0);
      check("async_rst_pwm", int'(pwm_out), 0);
      check("async_rst_at_target", int'(at_target), 1);
      tick(3);
      rst_n = 1'b1;
      highs = 0;
      for (int k = 0; k < 5 * P; k++) begin
         tick(1);
         highs += int'(pwm_out);
      end
      check("no_pulse_5_periods", highs, 0);

      // 2: cmd 5 at cycle 10 from a fresh start
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      highs = 0;
      cmd = 4'd5;
      for (int k = 0; k < 330; k++) begin
         cmd_valid = (k == 10);
         tick(1);
         if (k % 60 == 58 && k < 300) check("ramp_pre_step", int'(level_out), k / 60);
         if (k % 60 == 59 && k < 300) check("ramp_step", int'(level_out), (k + 1) / 60);
         if (k == 298) check("at_target_before", int'(at_target), 0);
         if (k == 299) check("at_target_level5", int'(at_target), 1);
         if (k >= 300) highs += int'(pwm_out);
      end
      cmd_valid = 1'b0;
      check("level5_high_cycles", highs, 10);

      // 3: full scale is a continuous high
      pulse(15);
      wait_level(15, 800);
      tick(1);
      highs = 0;
      for (int k = 0; k < 2 * P; k++) begin
         highs += int'(pwm_out);
         tick(1);
      end
      check("full_on_two_periods", highs, 2 * P);

      // 4: ramp 0->12, cmd 3 lands on the boundary that steps 8->9
      pulse(12);
      en = 1'b0;
      tick(1);
      en = 1'b1;
      cmd = 4'd3;
      for (int k = 0; k < 960; k++) begin
         cmd_valid = (k == 539);
         tick(1);
         if (k == 479) check("rev_level8", int'(level_out), 8);
         if (k == 539) check("rev_uses_old_target", int'(level_out), 9);
         if (k == 599) check("rev_down_8", int'(level_out), 8);
         if (k == 659) check("rev_down_7", int'(level_out), 7);
         if (k == 899) check("rev_down_3", int'(level_out), 3);
      end
      cmd_valid = 1'b0;
      check("rev_state_hold", int'(dut.state), int'(HOLD));
      check("rev_at_target", int'(at_target), 1);

      // 5: drop enable at level 10
      pulse(10);
      wait_level(10, 1000);
      en = 1'b0;
      tick(1);
      check("disable_pwm", int'(pwm_out), 0);
      check("disable_level", int'(level_out), 0);

      // 6: command while disabled is ignored; re-enable ramps to 10
      pulse(9);
      tick(5);
      check("disabled_level_held", int'(level_out), 0);
      en = 1'b1;
      for (int k = 0; k < 600; k++) begin
         tick(1);
         if (k == 59) check("reenable_level1", int'(level_out), 1);
         if (k == 119) check("reenable_level2", int'(level_out), 2);
         if (k == 539) check("reenable_not_at_9", int'(at_target), 0);
         if (k == 599) check("reenable_level10", int'(level_out), 10);
      end
      check("reenable_at_target", int'(at_target), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
Downstream consumer of the SPI slave's 4-bit command nibble and its valid pulse. It drives motor_pwm_signal in FpgaController, which is currently tied to 0.
- Each valid nibble sets a target speed level, 0..15.
- A soft-start/soft-stop ramp moves the applied level toward the target one step at a time, on PWM period boundaries only.
- A fixed-period PWM is generated from the applied level.

Parameters:
- PERIOD_CYCLES, 1000: FPGA_clk cycles per PWM period. Must be ≥ 30 and a multiple of 15.
- RAMP_PERIODS, 64: PWM periods between consecutive ramp steps. Must be ≥ 1.
- CNT_W, $clog2(PERIOD_CYCLES): width of the period counter.

Ports:
- FPGA_clk, input, 1: single system clock.
- FPGA_reset_n, input, 1: asynchronous, active-low reset.
- cmd_data, input, 4: speed command nibble from the SPI slave (spi_data_out).
- cmd_valid, input, 1: one-cycle strobe qualifying cmd_data (spi_data_valid_out).
- motor_enable, input, 1: level-sensitive enable. Low means immediate stop.
- pwm_out, output, 1: registered PWM to the motor driver.
- level_out, output, 4: currently applied level.
- at_target, output, 1: high when level_out equals the latched target.

Behaviour:
- Reset (async assert, sync-release use): period counter 0, ramp counter 0, target 0, level 0, state IDLE, pwm_out 0, level_out 0, at_target 1.
- Command latch: on cmd_valid=1, target <= cmd_data at that edge.
  - 1-cycle latency.
  - A repeated identical value has no effect.
  - cmd_valid is ignored while motor_enable=0; the target is held.
- Period counter: counts 0..PERIOD_CYCLES-1, then wraps to 0. The boundary is the cycle where the count equals PERIOD_CYCLES-1.
- Threshold:
  - thr = level × (PERIOD_CYCLES/15).
  - Level 0 gives a constant 0 output; level 15 gives constant 1 (thr = PERIOD_CYCLES).
  - Computed at constant width CNT_W+1; no overflow.
- PWM output: pwm_out <= (count < thr), so the output lags the counter by 1 cycle.
  - Exactly thr high cycles per period, high phase first.
  - level changes only at a boundary, so no glitch or truncated pulse occurs mid-period.
- Ramp counter: 0..RAMP_PERIODS-1, advanced at each boundary. A step is taken at a boundary where the ramp counter equals RAMP_PERIODS-1 and level ≠ target.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN, HOLD. All transitions are evaluated at boundaries only.
  - IDLE (level=0, target=0): target>0 → RAMP_UP.
  - RAMP_UP: level +1 per step; level==target → HOLD; target<level → RAMP_DOWN.
  - RAMP_DOWN: level −1 per step; level==target → HOLD, or IDLE if 0; target>level → RAMP_UP.
  - HOLD: target≠level → RAMP_UP or RAMP_DOWN as appropriate; target==0 and level==0 → IDLE.
  - Direction reversal does not reset the ramp counter.
- Simultaneous events:
  - cmd_valid on a boundary cycle: the step decision at that edge uses the old target. The new target takes effect from the next boundary.
- motor_enable=0:
  - Next edge: level <= 0, state <= IDLE, pwm_out <= 0.
  - Period and ramp counters <= 0 and held at 0.
  - Re-enable: counters restart from 0 and the block ramps from 0 toward the retained target.
- Reset mid-ramp: all state returns to reset values immediately and asynchronously.
- at_target is combinational from the level and target registers (level == target).

Decomposition:
- Package motor_pwm_pkg holds:
  - enum ramp_state_t {IDLE, RAMP_UP, RAMP_DOWN, HOLD};
  - localparam MAX_LEVEL = 15;
  - function level_to_thr(level, PERIOD_CYCLES).
- One sub-module, pwm_period_counter.
  - Parameter PERIOD_CYCLES; inputs clk, reset, clear.
  - Outputs count and boundary pulse.
  - Reusable by the later servo stage.

Test Plan (PERIOD_CYCLES=30, RAMP_PERIODS=2, so step=2):
1. Reset held low mid-run, then released:
   - pwm_out=0 and level_out=0 during and after reset.
   - at_target=1.
   - No pulse for 5 periods.
2. cmd 5 pulse at cycle 10:
   - level_out reaches 1, 2, 3, 4, 5 at boundaries spaced 60 cycles apart.
   - Each period then has 2×level high cycles; at level 5, exactly 10 high and 20 low per 30.
   - at_target rises when level_out=5.
3. cmd 15, then steady state: pwm_out constantly 1 across consecutive periods with no low gap.
4. At level 8 ramping up to 12, cmd 3 issued on a boundary cycle:
   - The step at that edge uses target 12 (level 9).
   - The next step goes down: 8, then 7, down to 3.
   - State is HOLD at the end.
5. motor_enable dropped at level 10:
   - Next cycle: pwm_out=0 and level_out=0.
   - Re-enable: ramps 1, 2, … toward the retained target 10.
6. cmd_valid pulsed with value 9 while motor_enable=0: ignored; after re-enable, the ramp targets the previous value.
